// File: rtl/crc_stream_feeder.sv
// crc_stream_feeder
//   Bus master that feeds a packet of 32-bit words into the CRC block hands-free.
//   Input words are buffered in a DEPTH-entry FIFO. On cfg_start the block programs
//   CTRL (WAS=1), POLY and the seed, re-writes CTRL (WAS=0), then writes one DATA word
//   per cycle from the FIFO. It finishes by reading DATA back into result and pulsing done.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   CRC_BASE   address of DATA; POLY = CRC_BASE+4, CTRL = CRC_BASE+8
//   IDLE_ADDR  address driven on cycles without an access
//   TIMEOUT    stall limit in STREAM (only with CRC_FEED_TIMEOUT_EN)
//
// Build option
//   CRC_FEED_TIMEOUT_EN  when defined, a run that stalls too long in STREAM aborts
//                        to DONE with err=1. Otherwise STREAM waits forever and err=0.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_start                1-cycle start pulse, ignored while busy
//   cfg_ctrl/poly/seed/len   run configuration, latched at start
//   s_valid, s_data, s_ready word stream input (s_ready = FIFO not full)
//   addr, RW, data_wr        CRC bus request (RW=1 write), decoded from state
//   data_rd                  CRC read data, combinational in the same cycle
//   busy                     not idle
//   done                     1-cycle pulse, result valid
//   result                   captured CRC, held until the next done
//   err                      timeout abort flag, only asserted with done
`timescale 1ns/1ps

module crc_stream_feeder #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] CRC_BASE  = 32'h4003_2000,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_poly,
  input  logic [31:0] cfg_seed,
  input  logic [15:0] cfg_len,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] addr,
  output logic        RW,
  output logic [31:0] data_wr,
  input  logic [31:0] data_rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [31:0] ADDR_DATA = CRC_BASE;
  localparam logic [31:0] ADDR_POLY = CRC_BASE + 32'd4;
  localparam logic [31:0] ADDR_CTRL = CRC_BASE + 32'd8;
  localparam logic [31:0] WAS_MASK  = 32'h0200_0000;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("crc_stream_feeder: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("crc_stream_feeder: TIMEOUT must be >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCtrlS,
    StPoly,
    StSeed,
    StCtrlR,
    StStream,
    StRead,
    StDone
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // FIFO: extra pointer bit distinguishes full from empty
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [31:0] fifo_head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rptr_q[AW-1:0]];
  assign s_ready    = ~fifo_full;
  assign push       = s_valid & ~fifo_full;
  assign pop        = (state_q == StStream) & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Run configuration and progress
  // ---------------------------------------------------------------------------
  logic [31:0] ctrl_q, poly_q, seed_q, result_q;
  logic [15:0] len_q, count_q;
  logic        last_word;
  logic        start;

  assign start = (state_q == StIdle) & cfg_start;
  // Compare against len-1 so len=16'hFFFF never needs count to reach 2^16.
  assign last_word = (count_q == len_q - 16'd1);

`ifdef CRC_FEED_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  // The DONE cycle itself is the last of TIMEOUT cycles without a pop, so done
  // lands exactly TIMEOUT cycles after the last pop.
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 2);

  logic [SW-1:0] stall_q;
  logic          err_q;
  logic          timeout;

  assign timeout = (state_q == StStream) & fifo_empty & (stall_q == STALL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q != StStream || pop) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_q + SW'(1);
      end
      if (start) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = (state_q == StDone) & err_q;
`else
  logic timeout;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      poly_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      if (start) begin
        ctrl_q  <= cfg_ctrl;
        poly_q  <= cfg_poly;
        seed_q  <= cfg_seed;
        len_q   <= cfg_len;
        count_q <= '0;
      end else if (pop) begin
        count_q <= count_q + 16'd1;
      end
      if (state_q == StRead) begin
        result_q <= data_rd;
      end
    end
  end

  assign result = result_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cfg_start) state_d = StCtrlS;
      StCtrlS:  state_d = StPoly;
      StPoly:   state_d = StSeed;
      StSeed:   state_d = StCtrlR;
      StCtrlR:  state_d = (len_q == 16'd0) ? StRead : StStream;
      StStream: begin
        if (pop && last_word) begin
          state_d = StRead;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StRead:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bus request decoded from the registered state and FIFO head.
  always_comb begin
    addr    = IDLE_ADDR;
    RW      = 1'b0;
    data_wr = 32'h0;
    unique case (state_q)
      StCtrlS: begin
        addr    = ADDR_CTRL;
        RW      = 1'b1;
        data_wr = ctrl_q | WAS_MASK;
      end
      StPoly: begin
        addr    = ADDR_POLY;
        RW      = 1'b1;
        data_wr = poly_q;
      end
      StSeed: begin
        addr    = ADDR_DATA;
        RW      = 1'b1;
        data_wr = seed_q;
      end
      StCtrlR: begin
        addr    = ADDR_CTRL;
        RW      = 1'b1;
        data_wr = ctrl_q & ~WAS_MASK;
      end
      StStream: begin
        if (!fifo_empty) begin
          addr    = ADDR_DATA;
          RW      = 1'b1;
          data_wr = fifo_head;
        end
      end
      StRead: begin
        addr = ADDR_DATA;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_crc_stream_feeder.sv
`timescale 1ns/1ps

module tb_crc_stream_feeder;

  localparam logic [31:0] CRC_BASE  = 32'h4003_2000;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;
  localparam logic [31:0] A_DATA    = 32'h4003_2000;
  localparam logic [31:0] A_POLY    = 32'h4003_2004;
  localparam logic [31:0] A_CTRL    = 32'h4003_2008;
  localparam int          TIMEOUT   = 256;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_ctrl, cfg_poly, cfg_seed;
  logic [15:0] cfg_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] addr;
  logic        RW;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        busy, done, err;
  logic [31:0] result;
  logic [31:0] stub_val;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // CRC block stub: DATA reads return stub_val combinationally.
  assign data_rd = (addr == A_DATA && !RW) ? stub_val : 32'h0;

  crc_stream_feeder #(
    .DEPTH    (8),
    .CRC_BASE (CRC_BASE),
    .IDLE_ADDR(IDLE_ADDR),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_ctrl (cfg_ctrl),
    .cfg_poly (cfg_poly),
    .cfg_seed (cfg_seed),
    .cfg_len  (cfg_len),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .addr     (addr),
    .RW       (RW),
    .data_wr  (data_wr),
    .data_rd  (data_rd),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: every cycle not at IDLE_ADDR is one access {addr, RW, wdata}.
  logic [64:0] acc_q[$];
  logic [64:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          last_data_cyc = 0;
  int          rw_viol = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (addr != IDLE_ADDR) begin
        acc_q.push_back({addr, RW, (RW ? data_wr : 32'h0)});
        if (addr == A_DATA && RW) last_data_cyc = cyc;
      end else if (RW) begin
        rw_viol++;
      end
    end
  end

  function automatic logic [64:0] acc(input logic [31:0] a, input logic rw, input logic [31:0] d);
    return {a, rw, d};
  endfunction

  function int seq_diff();
    int n;
    int m;
    n = (acc_q.size() > exp_q.size()) ? acc_q.size() - exp_q.size()
                                      : exp_q.size() - acc_q.size();
    m = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (acc_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_setup(input logic [31:0] c, input logic [31:0] p, input logic [31:0] s);
    exp_q.delete();
    exp_q.push_back(acc(A_CTRL, 1'b1, c | 32'h0200_0000));
    exp_q.push_back(acc(A_POLY, 1'b1, p));
    exp_q.push_back(acc(A_DATA, 1'b1, s));
    exp_q.push_back(acc(A_CTRL, 1'b1, c & ~32'h0200_0000));
  endtask

  // Leaves the bench #1 after the start edge, i.e. in the CTRL_S cycle (latency 1).
  task automatic start_run(input logic [31:0] c, input logic [31:0] p, input logic [31:0] s,
                           input logic [15:0] len);
    cfg_ctrl  = c;
    cfg_poly  = p;
    cfg_seed  = s;
    cfg_len   = len;
    acc_q.delete();
    rw_viol   = 0;
    mon_en    = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; lat counts cycles from the start edge.
  task automatic wait_done(input int budget, output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    @(negedge clk);
    while (lat <= budget) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [101:0] got;
    logic [101:0] want;
    @(negedge clk);
    got  = {addr, RW, data_wr, busy, done, result, err, s_ready};
    want = {IDLE_ADDR, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, want);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_prefilled();
    int lat;
    bit ok;
    stub_val = 32'hDEAD_BEEF;
    push_words(3, 32'h1111_0000);
    start_run(32'h0000_00A5, 32'h0000_1021, 32'hFFFF_FFFF, 16'd3);
    wait_done(40, lat, ok);
    expect_setup(32'h0000_00A5, 32'h0000_1021, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) exp_q.push_back(acc(A_DATA, 1'b1, 32'h1111_0000 + 32'(i)));
    exp_q.push_back(acc(A_DATA, 1'b0, 32'h0));
    n_vec++;
    if (!ok || lat !== 9) begin
      n_err++;
      $display("FAIL prefill_latency: got %0d (seen=%0d) expected 9", lat, ok);
    end
    n_vec++;
    if (result !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL prefill_result: got %h expected deadbeef", result);
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL prefill_err: got %b expected 0", err);
    end
    n_vec++;
    if (seq_diff() !== 0) begin
      n_err++;
      $display("FAIL prefill_bus_seq: got %0d accesses (%0d differ) expected %0d",
               acc_q.size(), seq_diff(), exp_q.size());
    end
    tick();
  endtask

  task automatic test_zero_len();
    int lat;
    bit ok;
    stub_val = 32'h1234_5678;
    start_run(32'h0000_0001, 32'h0000_8005, 32'h0000_0000, 16'd0);
    wait_done(40, lat, ok);
    expect_setup(32'h0000_0001, 32'h0000_8005, 32'h0000_0000);
    exp_q.push_back(acc(A_DATA, 1'b0, 32'h0));
    n_vec++;
    if (!ok || lat !== 6) begin
      n_err++;
      $display("FAIL zero_len_latency: got %0d (seen=%0d) expected 6", lat, ok);
    end
    n_vec++;
    if (seq_diff() !== 0 || result !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL zero_len_seq_result: got %0d accesses result %h expected 5 accesses 12345678",
               acc_q.size(), result);
    end
    // Start in the DONE cycle must be ignored.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done_ignored: busy got %b expected 0", busy);
    end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    bit ok;
    stub_val = 32'hCAFE_F00D;
    fork
      begin
        start_run(32'h0200_0003, 32'h04C1_1DB7, 32'h0000_0000, 16'd4);
        wait_done(100, lat, ok);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          tick();
          tick();
          s_valid = 1'b1;
          s_data  = 32'hA000_0000 + 32'(i);
          tick();
          s_valid = 1'b0;
        end
      end
    join
    expect_setup(32'h0200_0003, 32'h04C1_1DB7, 32'h0000_0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(acc(A_DATA, 1'b1, 32'hA000_0000 + 32'(i)));
    exp_q.push_back(acc(A_DATA, 1'b0, 32'h0));
    n_vec++;
    if (seq_diff() !== 0) begin
      n_err++;
      $display("FAIL stall_bus_seq: got %0d accesses (%0d differ) expected %0d",
               acc_q.size(), seq_diff(), exp_q.size());
    end
    n_vec++;
    if (rw_viol !== 0) begin
      n_err++;
      $display("FAIL stall_idle_rw: got %0d idle cycles with RW=1 expected 0", rw_viol);
    end
    n_vec++;
    if (!ok || lat !== 14) begin
      n_err++;
      $display("FAIL stall_latency: got %0d (seen=%0d) expected 14", lat, ok);
    end
    n_vec++;
    if (cyc - last_data_cyc !== 2) begin
      n_err++;
      $display("FAIL stall_done_after_last: got %0d expected 2", cyc - last_data_cyc);
    end
    n_vec++;
    if (result !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL stall_result: got %h expected cafef00d", result);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    int lat;
    bit ok;
    bit accepted;
    stub_val = 32'h0BAD_CAFE;
    push_words(8, 32'hB000_0000);
    @(negedge clk);
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_after_8: s_ready got %b expected 0", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 32'hB000_0008;
    tick();
    @(negedge clk);
    n_vec++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ninth_held: s_ready got %b expected 0", s_ready);
    end
    accepted = 1'b0;
    fork
      begin
        start_run(32'h0000_0000, 32'h0000_1021, 32'h0000_FFFF, 16'd9);
        wait_done(60, lat, ok);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (s_ready) begin
            tick();
            s_valid  = 1'b0;
            accepted = 1'b1;
            break;
          end
        end
      end
    join
    s_valid = 1'b0;
    expect_setup(32'h0000_0000, 32'h0000_1021, 32'h0000_FFFF);
    for (int i = 0; i < 9; i++) exp_q.push_back(acc(A_DATA, 1'b1, 32'hB000_0000 + 32'(i)));
    exp_q.push_back(acc(A_DATA, 1'b0, 32'h0));
    n_vec++;
    if (accepted !== 1'b1 || seq_diff() !== 0) begin
      n_err++;
      $display("FAIL ninth_word_stream: accepted %b, %0d accesses (%0d differ) expected 1, %0d",
               accepted, acc_q.size(), seq_diff(), exp_q.size());
    end
    n_vec++;
    if (!ok || lat !== 15) begin
      n_err++;
      $display("FAIL full_fifo_latency: got %0d (seen=%0d) expected 15", lat, ok);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit ok;
    logic [101:0] got;
    logic [101:0] want;
    stub_val = 32'h3333_3333;
    push_words(2, 32'hC000_0000);
    start_run(32'h0000_0000, 32'h0000_1021, 32'h0000_0000, 16'd5);
    repeat (6) tick();
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    got  = {addr, RW, data_wr, busy, done, result, err, s_ready};
    want = {IDLE_ADDR, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL midrun_reset_outputs: got %h expected %h", got, want);
    end
    tick();
    rst = 1'b1;
    stub_val = 32'h5A5A_5A5A;
    push_words(1, 32'hD000_0000);
    start_run(32'h0000_0010, 32'h0000_0007, 32'h1234_0000, 16'd1);
    wait_done(40, lat, ok);
    expect_setup(32'h0000_0010, 32'h0000_0007, 32'h1234_0000);
    exp_q.push_back(acc(A_DATA, 1'b1, 32'hD000_0000));
    exp_q.push_back(acc(A_DATA, 1'b0, 32'h0));
    n_vec++;
    if (!ok || lat !== 7 || seq_diff() !== 0) begin
      n_err++;
      $display("FAIL rerun_after_reset: lat %0d seen %0d, %0d accesses (%0d differ) expected 7, %0d",
               lat, ok, acc_q.size(), seq_diff(), exp_q.size());
    end
    n_vec++;
    if (result !== 32'h5A5A_5A5A) begin
      n_err++;
      $display("FAIL rerun_result: got %h expected 5a5a5a5a", result);
    end
    tick();
  endtask

`ifdef CRC_FEED_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    bit ok;
    stub_val = 32'h7777_7777;
    push_words(1, 32'hE000_0000);
    start_run(32'h0000_0000, 32'h0000_1021, 32'h0000_0000, 16'd2);
    wait_done(TIMEOUT + 50, lat, ok);
    expect_setup(32'h0000_0000, 32'h0000_1021, 32'h0000_0000);
    exp_q.push_back(acc(A_DATA, 1'b1, 32'hE000_0000));
    // Only pop is at latency 5.
    n_vec++;
    if (!ok || lat !== 5 + TIMEOUT || err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_done: lat %0d seen %0d err %b expected %0d, 1", lat, ok, err,
               5 + TIMEOUT);
    end
    n_vec++;
    if (result !== 32'h5A5A_5A5A || seq_diff() !== 0) begin
      n_err++;
      $display("FAIL timeout_no_read: result %h, %0d accesses expected 5a5a5a5a, %0d",
               result, acc_q.size(), exp_q.size());
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_ctrl  = '0;
    cfg_poly  = '0;
    cfg_seed  = '0;
    cfg_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    stub_val  = '0;
    #1 rst = 1'b0;
    test_reset();
    test_prefilled();
    test_zero_len();
    test_stall();
    test_back_pressure();
    test_reset_midrun();
`ifdef CRC_FEED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
